// File: rtl/instruction_fetch_stage.sv
// Fetch PC, instruction-memory req/ack handshake, skid buffer and IF/ID register.
// Latency: a word acked at edge N is on instruction after edge N. Stall parks one word in skid; redirect flushes.
module instruction_fetch_stage #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [23:0]       NOP      = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [23:0]       imem_rdata,
    output logic [23:0]       instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_FULL} state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_next_pc;
    logic [23:0]       r_skid_dat;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [23:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_vld;

    logic [ADDR_W-1:0] w_next_inc;
    logic [ADDR_W-1:0] w_redir_inc;
    logic              w_pending;

    assign w_next_inc  = r_next_pc + ONE;
    assign w_redir_inc = redirect_pc + ONE;
    assign w_pending   = (r_state == S_WAIT) || (r_state == S_DROP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_next_pc  <= RESET_PC + ONE;
            r_skid_dat <= NOP;
            r_skid_pc  <= RESET_PC;
            r_instr    <= NOP;
            r_pc       <= RESET_PC;
            r_vld      <= 1'b0;
        end else if (redirect) begin
            r_instr <= NOP;
            r_vld   <= 1'b0;
            r_req   <= 1'b1;
            // An unacked request cannot be withdrawn, so it is drained in DROP.
            if (w_pending && !imem_ack) begin
                r_state   <= S_DROP;
                r_next_pc <= redirect_pc;
            end else begin
                r_state   <= S_WAIT;
                r_addr    <= redirect_pc;
                r_next_pc <= w_redir_inc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_WAIT;
                    r_req   <= 1'b1;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        if (stall) begin
                            r_skid_dat <= imem_rdata;
                            r_skid_pc  <= r_addr;
                            r_state    <= S_FULL;
                            r_req      <= 1'b0;
                        end else begin
                            r_instr   <= imem_rdata;
                            r_pc      <= r_addr;
                            r_vld     <= 1'b1;
                            r_addr    <= r_next_pc;
                            r_next_pc <= w_next_inc;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_addr    <= r_next_pc;
                        r_next_pc <= w_next_inc;
                        r_state   <= S_WAIT;
                    end
                end
                S_FULL: begin
                    // next_pc still names the word after the skid entry.
                    if (!stall) begin
                        r_instr   <= r_skid_dat;
                        r_pc      <= r_skid_pc;
                        r_vld     <= 1'b1;
                        r_addr    <= r_next_pc;
                        r_next_pc <= w_next_inc;
                        r_state   <= S_WAIT;
                        r_req     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_instr;
    assign pc_out      = r_pc;
    assign instr_valid = r_vld;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Random and directed fetch stimulus; a flushable queue of expected program-order PCs scores every delivered word.
module tb_instruction_fetch_stage;
    localparam int AW = 16;
    localparam logic [23:0] NOP = 24'h000000;

    logic          clk = 1'b0;
    logic          reset, stall, redirect, imem_ack;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [23:0]   imem_rdata;
    logic [23:0]   instruction;
    logic [AW-1:0] pc_out;
    logic          instr_valid;

    int errors = 0;
    int checks = 0;
    int deliveries = 0;

    always #5 clk = ~clk;

    instruction_fetch_stage #(.ADDR_W(AW), .RESET_PC('0), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_out(pc_out), .instr_valid(instr_valid)
    );

    // Instruction memory contents: unique per address, with one planted word.
    function automatic logic [23:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'd5) return 24'h00A5A5;
        return {a[7:0] ^ 8'h3C, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected delivery stream: sequential PCs restarting at every reset or redirect target.
    logic [AW-1:0] exp_q[$];
    logic          flush_seen = 1'b0;
    logic          p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
    logic [AW-1:0] p_addr = '0;
    logic          last_vld = 1'b0;
    logic [AW-1:0] last_pc = '0;

    always @(posedge clk) begin
        if (reset || redirect) begin
            logic [AW-1:0] base;
            base = reset ? '0 : redirect_pc;
            exp_q.delete();
            for (int i = 0; i < 8; i++) exp_q.push_back(base + AW'(i));
            flush_seen <= 1'b1;
        end else begin
            flush_seen <= 1'b0;
        end
        p_req  <= imem_req;
        p_ack  <= imem_ack;
        p_rst  <= reset;
        p_addr <= imem_addr;
    end

    always @(negedge clk) begin
        logic [AW-1:0] p;
        if (flush_seen) check("bubble_after_flush", 32'(instr_valid), 32'(1'b0));
        if (p_req && !p_ack && !p_rst) begin
            check("req_held", 32'(imem_req), 32'(1'b1));
            check("addr_stable", 32'(imem_addr), 32'(p_addr));
        end
        if (instr_valid && (!last_vld || pc_out != last_pc)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got pc %h expected none", pc_out);
            end else begin
                p = exp_q.pop_front();
                exp_q.push_back(p + AW'(8));
                check("sb_pc", 32'(pc_out), 32'(p));
                check("sb_instr", 32'(instruction), 32'(mem_word(p)));
                deliveries++;
            end
        end
        last_vld <= instr_valid;
        last_pc  <= pc_out;
    end

    initial begin
        int d0;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'(1'b0));
        check("rst_addr", 32'(imem_addr), 32'(16'd0));
        check("rst_instr", 32'(instruction), 32'(NOP));
        check("rst_vld", 32'(instr_valid), 32'(1'b0));
        check("rst_pc", 32'(pc_out), 32'(16'd0));
        reset = 1'b0;

        // Zero-wait stream from reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("boot_addr", 32'(imem_addr), 32'(i));
            if (i == 1) check("boot_vld", 32'(instr_valid), 32'(1'b1));
        end

        // Wait states: ack every third cycle
        for (int k = 0; k < 12; k++) begin
            imem_ack = (k % 3 == 2);
            @(negedge clk);
        end

        // Stall over the ack of address 5
        redirect = 1'b1; redirect_pc = 16'd4; imem_ack = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        check("skid_addr5", 32'(imem_addr), 32'(16'd5));
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            check("full_no_req", 32'(imem_req), 32'(1'b0));
            check("full_hold_pc", 32'(pc_out), 32'(16'd4));
        end
        stall = 1'b0;
        @(negedge clk);
        check("skid_instr", 32'(instruction), 32'(24'h00A5A5));
        check("skid_pc", 32'(pc_out), 32'(16'd5));
        check("resume_addr", 32'(imem_addr), 32'(16'd6));

        // Redirect while waiting on address 7
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        check("drop_addr", 32'(imem_addr), 32'(16'd7));
        @(negedge clk);
        check("drop_vld", 32'(instr_valid), 32'(1'b0));
        imem_ack = 1'b1;
        @(negedge clk);
        check("redir_addr", 32'(imem_addr), 32'(16'h0040));
        check("redir_vld", 32'(instr_valid), 32'(1'b0));
        @(negedge clk);
        check("redir_land_pc", 32'(pc_out), 32'(16'h0040));
        check("redir_land_vld", 32'(instr_valid), 32'(1'b1));

        // Redirect, ack and stall together
        redirect = 1'b1; redirect_pc = 16'h0123; stall = 1'b1;
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        check("combo_instr", 32'(instruction), 32'(NOP));
        check("combo_vld", 32'(instr_valid), 32'(1'b0));
        check("combo_pc_kept", 32'(pc_out), 32'(16'h0040));
        check("combo_addr", 32'(imem_addr), 32'(16'h0123));

        // PC wrap-around
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        check("wrap_a", 32'(imem_addr), 32'(16'hFFFE));
        @(negedge clk);
        check("wrap_b", 32'(imem_addr), 32'(16'hFFFF));
        @(negedge clk);
        check("wrap_c", 32'(imem_addr), 32'(16'h0000));
        @(negedge clk);
        check("wrap_d", 32'(imem_addr), 32'(16'h0001));

        // Full throughput with ack held high
        @(posedge clk); #1;
        d0 = deliveries;
        repeat (8) @(posedge clk);
        #1;
        check("throughput", 32'(deliveries - d0), 32'(8));

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            imem_ack    = ($urandom_range(0, 2) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = AW'($urandom);
        end
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with a request outstanding
        imem_ack = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(imem_req), 32'(1'b0));
        check("midrst_addr", 32'(imem_addr), 32'(16'd0));
        check("midrst_vld", 32'(instr_valid), 32'(1'b0));
        reset = 1'b0; imem_ack = 1'b1;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
